dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Miss/store controller in front of the 128-line direct-mapped data cache array. Accepts loads and stores
//  from the LSQ, looks loads up through the array read port, tracks misses in a small MSHR table, drives
//  the shared memory bus (LOAD/STORE, 4-bit tag protocol), fills the array on return, reports completions.
// PARAMETERS
//  NUM_MSHR  4  outstanding load misses (2..8)
//  LDID_W    3  width of LSQ load identifier returned with completions
// PORTS
//  clock            in   1   system clock
//  reset            in   1   synchronous, active-high
//  ld_en            in   1   load request valid (accepted when ld_stall=0)
//  ld_addr          in   64  load byte address; [9:3]=idx, [31:10]=tag
//  ld_id            in   LDID_W  LSQ id, echoed on completion
//  ld_stall         out  1   load not accepted this cycle (comb)
//  st_en            in   1   store request valid (accepted when st_stall=0)
//  st_addr, st_data in   64  store address / full 64-bit word
//  st_stall         out  1   store buffer occupied (registered)
//  done_valid       out  1   load completion (registered)
//  done_id          out  LDID_W  completing load id
//  done_data        out  64  completing load data
//  rd_idx, rd_tag   out  7,22  array lookup (comb from ld_addr)
//  rd_data, rd_valid in  64,1  array lookup result
//  fill_en/idx/tag/data out 1,7,22,64  array port 1 (miss fill)
//  stw_en/idx/tag/data  out 1,7,22,64  array port 0 (store write)
//  mem_cmd          out  2   0 NONE, 1 LOAD, 2 STORE
//  mem_addr, mem_wdata out 64  bus address (low 3 bits zero) / store data
//  mem_resp         in   4   accepting tag, 0 = rejected
//  mem_rtag, mem_rdata in 4,64  returning tag (0 = none) / data
//  idle             out  1   no MSHR or store buffer busy
// BEHAVIOUR
//  Reset: all MSHRs EMPTY, store buffer empty; done_valid, fill_en, stw_en=0, mem_cmd=NONE, idle=1.
//  Responses arriving after reset match no entry and are dropped.
//  MSHR states: EMPTY -> WAIT_ISSUE (miss accepted) -> WAIT_DATA (mem_resp!=0 on issue) -> EMPTY (mem_rtag match).
//  Load hit (ld_en & ~ld_stall & rd_valid): done_* asserted next cycle with rd_data, 1-cycle latency.
//  Load miss: allocate lowest-index EMPTY entry, store addr, id, line; no merging of same-line misses.
//  ld_stall = no EMPTY entry | mem_rtag matches a WAIT_DATA entry (fill owns done port this cycle).
//  Bus arbitration, one command/cycle: store buffer first, else lowest-index WAIT_ISSUE entry.
//  Issue rejected (mem_resp=0): retry next cycle, state unchanged. Accepted: record mem_resp as entry tag.
//  Fill: mem_rtag==entry tag -> same cycle fill_en=1 (unless nofill), done_* next cycle with mem_rdata,
//  entry EMPTY next cycle. Each returning tag matches at most one entry.
//  Store accept: word written to array via stw_* same cycle (write-allocate, full line), buffered,
//  st_stall=1 from next cycle until issued with mem_resp!=0; freed that edge. Write-through, no response tag.
//  Store accept sets nofill on every live MSHR with same idx+tag: its load still completes with memory data
//  but fill_en suppressed, so stale data never overwrites the newer word.
//  Same-cycle fill and stw to one idx: stw wins (array gives port 1 priority, so stw_en forces fill_en=0).
//  idle = all EMPTY & store buffer empty (used by halt drain).
// STRUCTURE
//  Package dcache_pkg: MEM_NONE/LOAD/STORE, IDX/TAG field bounds, mshr_state_t enum.
//  Sub-module dcache_mshr: entry table, alloc/issue priority encoders, tag match; arbitration stays here.
// TESTING
//  Hit: preload idx 5 tag 0x3 with 0xAA; load 0xC28 id 2 -> next cycle done id 2 data 0xAA, mem_cmd NONE.
//  Miss: load 0x2000, mem_resp=7, rtag 7 data 0x55 after 10 cycles -> fill idx 0 + done 0x55 next cycle.
//  Reject: mem_resp=0 for 3 cycles -> LOAD re-driven each cycle, accepted on 4th, one fill only.
//  Full: 4 misses outstanding, 5th load -> ld_stall=1 until first rtag returns, then accepted.
//  Store race: miss 0x40 issued, store 0x40=0x99 -> stw writes 0x99, return 0x11 -> done 0x11, no fill.
//  Reset with 2 misses in flight -> idle=1; later rtags ignored, no done_valid/fill_en.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared encodings for the data-cache miss/store controller: bus commands,
// address field bounds and the MSHR entry state.
package dcache_pkg;

   localparam logic [1:0] MEM_NONE  = 2'd0;
   localparam logic [1:0] MEM_LOAD  = 2'd1;
   localparam logic [1:0] MEM_STORE = 2'd2;

   localparam int IDX_LO = 3;
   localparam int IDX_HI = 9;
   localparam int TAG_LO = 10;
   localparam int TAG_HI = 31;
   localparam int IDX_W  = IDX_HI - IDX_LO + 1;
   localparam int TAG_W  = TAG_HI - TAG_LO + 1;

   typedef enum logic [1:0] {
      MS_EMPTY      = 2'd0,
      MS_WAIT_ISSUE = 2'd1,
      MS_WAIT_DATA  = 2'd2
   } mshr_state_t;

endpackage

// File: rtl/dcache_mshr.sv
// Miss status table: per-entry state machine, lowest-index allocate/issue
// selection and return-tag match. Bus arbitration lives in the parent.
module dcache_mshr
   import dcache_pkg::*;
#(
   parameter int NUM_MSHR = 4,
   parameter int LDID_W   = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  i_alloc_en,
   input  logic [63:0]           i_alloc_addr,
   input  logic [LDID_W-1:0]     i_alloc_id,
   input  logic                  i_alloc_nofill,
   input  logic                  i_issue_acc,
   input  logic [3:0]            i_issue_tag,
   input  logic [3:0]            i_rtag,
   input  logic                  i_st_snoop,
   input  logic [TAG_HI:IDX_LO]  i_st_line,
   output logic                  o_has_empty,
   output logic                  o_issue_valid,
   output logic [63:0]           o_issue_addr,
   output logic                  o_match,
   output logic                  o_match_nofill,
   output logic [LDID_W-1:0]     o_match_id,
   output logic [IDX_W-1:0]      o_fill_idx,
   output logic [TAG_W-1:0]      o_fill_tag,
   output logic [2*NUM_MSHR-1:0] o_state
);

   localparam int SEL_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

   mshr_state_t       r_state  [NUM_MSHR];
   logic [63:0]       r_addr   [NUM_MSHR];
   logic [LDID_W-1:0] r_id     [NUM_MSHR];
   logic [3:0]        r_mtag   [NUM_MSHR];
   logic              r_nofill [NUM_MSHR];

   logic [SEL_W-1:0]  w_alloc_idx;
   logic [SEL_W-1:0]  w_issue_idx;
   logic [SEL_W-1:0]  w_match_idx;

   // Descending scan so the lowest qualifying index is the one left selected.
   always_comb begin
      o_has_empty   = 1'b0;
      o_issue_valid = 1'b0;
      o_match       = 1'b0;
      w_alloc_idx   = '0;
      w_issue_idx   = '0;
      w_match_idx   = '0;
      o_state       = '0;
      for (int i = NUM_MSHR - 1; i >= 0; i--) begin
         o_state[2*i +: 2] = r_state[i];
         if (r_state[i] == MS_EMPTY) begin
            o_has_empty = 1'b1;
            w_alloc_idx = SEL_W'(i);
         end
         if (r_state[i] == MS_WAIT_ISSUE) begin
            o_issue_valid = 1'b1;
            w_issue_idx   = SEL_W'(i);
         end
         if (r_state[i] == MS_WAIT_DATA && r_mtag[i] == i_rtag && i_rtag != 4'd0) begin
            o_match     = 1'b1;
            w_match_idx = SEL_W'(i);
         end
      end
      o_issue_addr   = r_addr[w_issue_idx] & ~64'h7;
      o_match_nofill = r_nofill[w_match_idx];
      o_match_id     = r_id[w_match_idx];
      o_fill_idx     = r_addr[w_match_idx][IDX_HI:IDX_LO];
      o_fill_tag     = r_addr[w_match_idx][TAG_HI:TAG_LO];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_MSHR; i++) begin
            r_state[i]  <= MS_EMPTY;
            r_addr[i]   <= '0;
            r_id[i]     <= '0;
            r_mtag[i]   <= '0;
            r_nofill[i] <= 1'b0;
         end
      end else begin
         // A newer store to the same line makes any later fill of that line stale.
         for (int i = 0; i < NUM_MSHR; i++) begin
            if (i_st_snoop && r_state[i] != MS_EMPTY &&
                r_addr[i][TAG_HI:IDX_LO] == i_st_line)
               r_nofill[i] <= 1'b1;
         end
         if (i_alloc_en) begin
            r_state[w_alloc_idx]  <= MS_WAIT_ISSUE;
            r_addr[w_alloc_idx]   <= i_alloc_addr;
            r_id[w_alloc_idx]     <= i_alloc_id;
            r_nofill[w_alloc_idx] <= i_alloc_nofill;
         end
         if (i_issue_acc) begin
            r_state[w_issue_idx] <= MS_WAIT_DATA;
            r_mtag[w_issue_idx]  <= i_issue_tag;
         end
         if (o_match)
            r_state[w_match_idx] <= MS_EMPTY;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Miss/store controller for the direct-mapped data cache: load lookup, MSHR
// tracking, single-entry write-through store buffer and memory bus driver.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int NUM_MSHR = 4,
   parameter int LDID_W   = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ld_en,
   input  logic [63:0]       ld_addr,
   input  logic [LDID_W-1:0] ld_id,
   output logic              ld_stall,
   input  logic              st_en,
   input  logic [63:0]       st_addr,
   input  logic [63:0]       st_data,
   output logic              st_stall,
   output logic              done_valid,
   output logic [LDID_W-1:0] done_id,
   output logic [63:0]       done_data,
   output logic [6:0]        rd_idx,
   output logic [21:0]       rd_tag,
   input  logic [63:0]       rd_data,
   input  logic              rd_valid,
   output logic              fill_en,
   output logic [6:0]        fill_idx,
   output logic [21:0]       fill_tag,
   output logic [63:0]       fill_data,
   output logic              stw_en,
   output logic [6:0]        stw_idx,
   output logic [21:0]       stw_tag,
   output logic [63:0]       stw_data,
   output logic [1:0]        mem_cmd,
   output logic [63:0]       mem_addr,
   output logic [63:0]       mem_wdata,
   input  logic [3:0]        mem_resp,
   input  logic [3:0]        mem_rtag,
   input  logic [63:0]       mem_rdata,
   output logic              idle
);

   // Handshakes: a load/store transfers on a cycle with en=1 and stall=0; a bus
   // command transfers on a cycle with mem_cmd!=NONE and mem_resp!=0, else it is
   // re-driven next cycle. Returns are matched by mem_rtag, never back-pressured.

   logic                  r_sb_valid;
   logic [63:0]           r_sb_addr;
   logic [63:0]           r_sb_data;
   logic                  r_done_valid;
   logic [LDID_W-1:0]     r_done_id;
   logic [63:0]           r_done_data;

   logic                  w_has_empty;
   logic                  w_issue_valid;
   logic [63:0]           w_issue_addr;
   logic                  w_match;
   logic                  w_match_nofill;
   logic [LDID_W-1:0]     w_match_id;
   logic [IDX_W-1:0]      w_fill_idx;
   logic [TAG_W-1:0]      w_fill_tag;
   logic [2*NUM_MSHR-1:0] w_mshr_state;
   logic                  w_ld_acc;
   logic                  w_hit;
   logic                  w_miss;
   logic                  w_st_acc;
   logic                  w_resp_ok;
   logic                  w_issue_acc;
   logic                  w_alloc_nofill;
   logic                  w_all_empty;

   assign w_resp_ok = (mem_resp != 4'd0);
   assign ld_stall  = ~w_has_empty | w_match;
   assign w_ld_acc  = ld_en & ~ld_stall;
   assign w_hit     = w_ld_acc & rd_valid;
   assign w_miss    = w_ld_acc & ~rd_valid;
   assign w_st_acc  = st_en & ~r_sb_valid;
   assign st_stall  = r_sb_valid;

   assign rd_idx = ld_addr[IDX_HI:IDX_LO];
   assign rd_tag = ld_addr[TAG_HI:TAG_LO];

   assign stw_en   = w_st_acc;
   assign stw_idx  = st_addr[IDX_HI:IDX_LO];
   assign stw_tag  = st_addr[TAG_HI:TAG_LO];
   assign stw_data = st_data;

   // The array favours port 1, so a store write to the same index must block the fill.
   assign fill_en   = w_match & ~w_match_nofill & ~(w_st_acc && stw_idx == w_fill_idx);
   assign fill_idx  = w_fill_idx;
   assign fill_tag  = w_fill_tag;
   assign fill_data = mem_rdata;

   assign w_alloc_nofill = w_st_acc && (st_addr[TAG_HI:IDX_LO] == ld_addr[TAG_HI:IDX_LO]);
   assign w_issue_acc    = ~r_sb_valid & w_issue_valid & w_resp_ok;

   always_comb begin
      mem_cmd   = MEM_NONE;
      mem_addr  = '0;
      mem_wdata = '0;
      if (r_sb_valid) begin
         mem_cmd   = MEM_STORE;
         mem_addr  = r_sb_addr & ~64'h7;
         mem_wdata = r_sb_data;
      end else if (w_issue_valid) begin
         mem_cmd  = MEM_LOAD;
         mem_addr = w_issue_addr;
      end
   end

   always_comb begin
      w_all_empty = 1'b1;
      for (int i = 0; i < NUM_MSHR; i++)
         if (w_mshr_state[2*i +: 2] != MS_EMPTY) w_all_empty = 1'b0;
   end
   assign idle = w_all_empty & ~r_sb_valid;

   dcache_mshr #(
      .NUM_MSHR (NUM_MSHR),
      .LDID_W   (LDID_W)
   ) u_mshr (
      .clock          (clock),
      .reset          (reset),
      .i_alloc_en     (w_miss),
      .i_alloc_addr   (ld_addr),
      .i_alloc_id     (ld_id),
      .i_alloc_nofill (w_alloc_nofill),
      .i_issue_acc    (w_issue_acc),
      .i_issue_tag    (mem_resp),
      .i_rtag         (mem_rtag),
      .i_st_snoop     (w_st_acc),
      .i_st_line      (st_addr[TAG_HI:IDX_LO]),
      .o_has_empty    (w_has_empty),
      .o_issue_valid  (w_issue_valid),
      .o_issue_addr   (w_issue_addr),
      .o_match        (w_match),
      .o_match_nofill (w_match_nofill),
      .o_match_id     (w_match_id),
      .o_fill_idx     (w_fill_idx),
      .o_fill_tag     (w_fill_tag),
      .o_state        (w_mshr_state)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sb_valid   <= 1'b0;
         r_sb_addr    <= '0;
         r_sb_data    <= '0;
         r_done_valid <= 1'b0;
         r_done_id    <= '0;
         r_done_data  <= '0;
      end else begin
         if (w_st_acc) begin
            r_sb_valid <= 1'b1;
            r_sb_addr  <= st_addr;
            r_sb_data  <= st_data;
         end else if (r_sb_valid && w_resp_ok) begin
            r_sb_valid <= 1'b0;
         end
         r_done_valid <= w_match | w_hit;
         if (w_match) begin
            r_done_id   <= w_match_id;
            r_done_data <= mem_rdata;
         end else if (w_hit) begin
            r_done_id   <= ld_id;
            r_done_data <= rd_data;
         end
      end
   end

   assign done_valid = r_done_valid;
   assign done_id    = r_done_id;
   assign done_data  = r_done_data;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a behavioural cache array; completions
// and fills are compared against expected queues by a negedge monitor.
module tb_dcache_ctrl;
   import dcache_pkg::*;

   localparam int LDID_W = 3;

   logic              clock = 1'b0;
   logic              reset;
   logic              ld_en;
   logic [63:0]       ld_addr;
   logic [LDID_W-1:0] ld_id;
   logic              ld_stall;
   logic              st_en;
   logic [63:0]       st_addr;
   logic [63:0]       st_data;
   logic              st_stall;
   logic              done_valid;
   logic [LDID_W-1:0] done_id;
   logic [63:0]       done_data;
   logic [6:0]        rd_idx;
   logic [21:0]       rd_tag;
   logic [63:0]       rd_data;
   logic              rd_valid;
   logic              fill_en;
   logic [6:0]        fill_idx;
   logic [21:0]       fill_tag;
   logic [63:0]       fill_data;
   logic              stw_en;
   logic [6:0]        stw_idx;
   logic [21:0]       stw_tag;
   logic [63:0]       stw_data;
   logic [1:0]        mem_cmd;
   logic [63:0]       mem_addr;
   logic [63:0]       mem_wdata;
   logic [3:0]        mem_resp;
   logic [3:0]        mem_rtag;
   logic [63:0]       mem_rdata;
   logic              idle;

   dcache_ctrl #(.NUM_MSHR(4), .LDID_W(LDID_W)) dut (
      .clock(clock), .reset(reset),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_id(ld_id), .ld_stall(ld_stall),
      .st_en(st_en), .st_addr(st_addr), .st_data(st_data), .st_stall(st_stall),
      .done_valid(done_valid), .done_id(done_id), .done_data(done_data),
      .rd_idx(rd_idx), .rd_tag(rd_tag), .rd_data(rd_data), .rd_valid(rd_valid),
      .fill_en(fill_en), .fill_idx(fill_idx), .fill_tag(fill_tag), .fill_data(fill_data),
      .stw_en(stw_en), .stw_idx(stw_idx), .stw_tag(stw_tag), .stw_data(stw_data),
      .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_resp(mem_resp), .mem_rtag(mem_rtag), .mem_rdata(mem_rdata),
      .idle(idle)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish within time limit");
      $fatal(1);
   end

   // ---------------- behavioural cache array ----------------
   logic        arr_clr;
   logic        pre_en;
   logic [6:0]  pre_idx;
   logic [21:0] pre_tag;
   logic [63:0] pre_data;
   logic        arr_v    [128];
   logic [21:0] arr_tag  [128];
   logic [63:0] arr_data [128];

   assign rd_valid = arr_v[rd_idx] && (arr_tag[rd_idx] == rd_tag);
   assign rd_data  = arr_data[rd_idx];

   always @(posedge clock) begin
      if (arr_clr) begin
         for (int i = 0; i < 128; i++) begin
            arr_v[i]    <= 1'b0;
            arr_tag[i]  <= '0;
            arr_data[i] <= '0;
         end
      end else begin
         if (pre_en) begin
            arr_v[pre_idx] <= 1'b1; arr_tag[pre_idx] <= pre_tag; arr_data[pre_idx] <= pre_data;
         end
         if (fill_en) begin
            arr_v[fill_idx] <= 1'b1; arr_tag[fill_idx] <= fill_tag; arr_data[fill_idx] <= fill_data;
         end
         if (stw_en) begin
            arr_v[stw_idx] <= 1'b1; arr_tag[stw_idx] <= stw_tag; arr_data[stw_idx] <= stw_data;
         end
      end
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [66:0] exp_done_q[$];
   logic [92:0] exp_fill_q[$];
   logic [66:0] e_done;
   logic [92:0] e_fill;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_done(input logic [2:0] id, input logic [63:0] d);
      exp_done_q.push_back({id, d});
   endtask

   task automatic push_fill(input logic [6:0] idx, input logic [21:0] tag, input logic [63:0] d);
      exp_fill_q.push_back({idx, tag, d});
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (done_valid) begin
            if (exp_done_q.size() == 0) chk("done_unexpected", 64'(done_valid), 64'd0);
            else begin
               e_done = exp_done_q.pop_front();
               chk("done_id", 64'(done_id), 64'(e_done[66:64]));
               chk("done_data", done_data, e_done[63:0]);
            end
         end
         if (fill_en) begin
            if (exp_fill_q.size() == 0) chk("fill_unexpected", 64'(fill_en), 64'd0);
            else begin
               e_fill = exp_fill_q.pop_front();
               chk("fill_idx", 64'(fill_idx), 64'(e_fill[92:86]));
               chk("fill_tag", 64'(fill_tag), 64'(e_fill[85:64]));
               chk("fill_data", fill_data, e_fill[63:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clock);
   endtask

   task automatic load(input logic [63:0] a, input logic [2:0] id);
      ld_en = 1'b1; ld_addr = a; ld_id = id;
   endtask

   // ---------------- directed sequence ----------------
   logic [3:0] rt [4];

   initial begin
      reset = 1'b1; arr_clr = 1'b1; pre_en = 1'b0; pre_idx = '0; pre_tag = '0; pre_data = '0;
      ld_en = 1'b0; ld_addr = '0; ld_id = '0; st_en = 1'b0; st_addr = '0; st_data = '0;
      mem_resp = '0; mem_rtag = '0; mem_rdata = '0;
      rt[0] = 4'd2; rt[1] = 4'd3; rt[2] = 4'd4; rt[3] = 4'd6;
      step(); step();
      reset = 1'b0; arr_clr = 1'b0;

      // reset state
      at_neg();
      chk("rst_idle", 64'(idle), 64'd1);
      chk("rst_done_valid", 64'(done_valid), 64'd0);
      chk("rst_fill_en", 64'(fill_en), 64'd0);
      chk("rst_stw_en", 64'(stw_en), 64'd0);
      chk("rst_mem_cmd", 64'(mem_cmd), 64'(MEM_NONE));
      chk("rst_st_stall", 64'(st_stall), 64'd0);
      step();

      // hit: idx 5 tag 3 holds 0xAA
      pre_en = 1'b1; pre_idx = 7'd5; pre_tag = 22'd3; pre_data = 64'hAA; step(); pre_en = 1'b0;
      load(64'hC28, 3'd2); push_done(3'd2, 64'hAA);
      at_neg();
      chk("hit_stall", 64'(ld_stall), 64'd0);
      chk("hit_rd_idx", 64'(rd_idx), 64'd5);
      chk("hit_rd_tag", 64'(rd_tag), 64'd3);
      step();
      ld_en = 1'b0;
      at_neg();
      chk("hit_latency", 64'(done_valid), 64'd1);
      chk("hit_mem_cmd", 64'(mem_cmd), 64'(MEM_NONE));
      chk("hit_idle", 64'(idle), 64'd1);
      step();

      // miss 0x2000, accepted with tag 7, data returns 10 cycles later
      load(64'h2000, 3'd1); at_neg(); chk("miss_stall", 64'(ld_stall), 64'd0); step();
      ld_en = 1'b0; mem_resp = 4'd7;
      at_neg();
      chk("miss_cmd", 64'(mem_cmd), 64'(MEM_LOAD));
      chk("miss_addr", mem_addr, 64'h2000);
      chk("miss_busy", 64'(idle), 64'd0);
      step();
      mem_resp = 4'd0; at_neg(); chk("miss_no_reissue", 64'(mem_cmd), 64'(MEM_NONE)); step();
      repeat (9) step();
      mem_rtag = 4'd7; mem_rdata = 64'h55;
      push_fill(7'd0, 22'd8, 64'h55); push_done(3'd1, 64'h55);
      at_neg();
      chk("miss_fill_en", 64'(fill_en), 64'd1);
      chk("miss_fill_stall", 64'(ld_stall), 64'd1);
      step();
      mem_rtag = 4'd0; at_neg(); chk("miss_done", 64'(done_valid), 64'd1); step();
      at_neg(); chk("miss_idle", 64'(idle), 64'd1); step();

      // reject three times, accept on the fourth
      load(64'h3008, 3'd3); step(); ld_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         at_neg();
         chk("rej_cmd", 64'(mem_cmd), 64'(MEM_LOAD));
         chk("rej_addr", mem_addr, 64'h3008);
         step();
      end
      mem_resp = 4'd5; at_neg(); chk("rej_accept_cmd", 64'(mem_cmd), 64'(MEM_LOAD)); step();
      mem_resp = 4'd0; at_neg(); chk("rej_no_reissue", 64'(mem_cmd), 64'(MEM_NONE)); step();
      mem_rtag = 4'd5; mem_rdata = 64'h77;
      push_fill(7'd1, 22'hC, 64'h77); push_done(3'd3, 64'h77);
      step();
      mem_rtag = 4'd0; step(); step();

      // four outstanding misses, fifth load stalls until a return frees an entry
      load(64'h4000, 3'd0); at_neg(); chk("full_ld0_stall", 64'(ld_stall), 64'd0); step();
      load(64'h4008, 3'd1); mem_resp = 4'd1; at_neg(); chk("full_iss0", mem_addr, 64'h4000); step();
      load(64'h4010, 3'd2); mem_resp = 4'd2; at_neg(); chk("full_iss1", mem_addr, 64'h4008); step();
      load(64'h4018, 3'd3); mem_resp = 4'd3; at_neg(); chk("full_iss2", mem_addr, 64'h4010); step();
      load(64'h4020, 3'd4); mem_resp = 4'd4;
      at_neg(); chk("full_iss3", mem_addr, 64'h4018); chk("full_stall", 64'(ld_stall), 64'd1); step();
      mem_resp = 4'd0;
      for (int k = 0; k < 3; k++) begin
         at_neg(); chk("full_stall_hold", 64'(ld_stall), 64'd1); step();
      end
      mem_rtag = 4'd1; mem_rdata = 64'h101;
      push_fill(7'd0, 22'h10, 64'h101); push_done(3'd0, 64'h101);
      at_neg(); chk("full_stall_on_fill", 64'(ld_stall), 64'd1); step();
      mem_rtag = 4'd0; at_neg(); chk("full_freed", 64'(ld_stall), 64'd0); step();
      ld_en = 1'b0; mem_resp = 4'd6;
      at_neg(); chk("full_iss4_cmd", 64'(mem_cmd), 64'(MEM_LOAD)); chk("full_iss4", mem_addr, 64'h4020); step();
      mem_resp = 4'd0;
      for (int k = 0; k < 4; k++) begin
         mem_rtag = rt[k]; mem_rdata = 64'h102 + 64'(k);
         push_fill(7'(k + 1), 22'h10, 64'h102 + 64'(k));
         push_done(3'(k + 1), 64'h102 + 64'(k));
         step();
      end
      mem_rtag = 4'd0; step();
      at_neg(); chk("full_idle", 64'(idle), 64'd1); step();

      // store races an outstanding miss to the same line
      load(64'h40, 3'd5); step();
      ld_en = 1'b0; mem_resp = 4'd9; at_neg(); chk("race_ld_cmd", 64'(mem_cmd), 64'(MEM_LOAD)); step();
      mem_resp = 4'd0; st_en = 1'b1; st_addr = 64'h40; st_data = 64'h99;
      at_neg();
      chk("race_stw_en", 64'(stw_en), 64'd1);
      chk("race_stw_idx", 64'(stw_idx), 64'd8);
      chk("race_stw_tag", 64'(stw_tag), 64'd0);
      chk("race_stw_data", stw_data, 64'h99);
      chk("race_st_stall0", 64'(st_stall), 64'd0);
      step();
      st_en = 1'b0;
      at_neg();
      chk("race_st_stall1", 64'(st_stall), 64'd1);
      chk("race_st_cmd", 64'(mem_cmd), 64'(MEM_STORE));
      chk("race_st_addr", mem_addr, 64'h40);
      chk("race_st_wdata", mem_wdata, 64'h99);
      step();
      mem_resp = 4'd10; at_neg(); chk("race_st_retry", 64'(mem_cmd), 64'(MEM_STORE)); step();
      mem_resp = 4'd0;
      at_neg(); chk("race_st_freed", 64'(st_stall), 64'd0); chk("race_cmd_none", 64'(mem_cmd), 64'(MEM_NONE)); step();
      mem_rtag = 4'd9; mem_rdata = 64'h11; push_done(3'd5, 64'h11);
      at_neg(); chk("race_nofill", 64'(fill_en), 64'd0); step();
      mem_rtag = 4'd0; step();
      load(64'h40, 3'd6); push_done(3'd6, 64'h99); step(); ld_en = 1'b0; step();

      // fill and store write to the same index in one cycle
      load(64'h5000, 3'd7); step();
      ld_en = 1'b0; mem_resp = 4'hB; at_neg(); chk("coll_ld_cmd", 64'(mem_cmd), 64'(MEM_LOAD)); step();
      mem_resp = 4'd0; step();
      mem_rtag = 4'hB; mem_rdata = 64'h66; st_en = 1'b1; st_addr = 64'h5400; st_data = 64'h77;
      push_done(3'd7, 64'h66);
      at_neg(); chk("coll_stw_en", 64'(stw_en), 64'd1); chk("coll_fill_blocked", 64'(fill_en), 64'd0); step();
      mem_rtag = 4'd0; st_en = 1'b0; mem_resp = 4'd1;
      at_neg(); chk("coll_st_cmd", 64'(mem_cmd), 64'(MEM_STORE)); chk("coll_st_addr", mem_addr, 64'h5400); step();
      mem_resp = 4'd0; load(64'h5400, 3'd0); push_done(3'd0, 64'h77);
      at_neg(); chk("coll_hit_stall", 64'(ld_stall), 64'd0); step();
      ld_en = 1'b0; step(); step();

      // reset with two misses in flight; their returns must be ignored
      load(64'h6000, 3'd1); step();
      load(64'h6008, 3'd2); mem_resp = 4'd3; step();
      ld_en = 1'b0; mem_resp = 4'd4; at_neg(); chk("rst2_iss", mem_addr, 64'h6008); step();
      mem_resp = 4'd0; at_neg(); chk("rst2_busy", 64'(idle), 64'd0); step();
      reset = 1'b1; step();
      reset = 1'b0;
      at_neg(); chk("rst2_idle", 64'(idle), 64'd1); chk("rst2_cmd", 64'(mem_cmd), 64'(MEM_NONE)); step();
      mem_rtag = 4'd3; mem_rdata = 64'hDEAD;
      at_neg(); chk("rst2_nofill3", 64'(fill_en), 64'd0); chk("rst2_nostall", 64'(ld_stall), 64'd0); step();
      mem_rtag = 4'd4;
      at_neg(); chk("rst2_nofill4", 64'(fill_en), 64'd0); chk("rst2_nodone3", 64'(done_valid), 64'd0); step();
      mem_rtag = 4'd0;
      at_neg(); chk("rst2_nodone4", 64'(done_valid), 64'd0); step();

      repeat (3) step();
      chk("done_q_drained", 64'(exp_done_q.size()), 64'd0);
      chk("fill_q_drained", 64'(exp_fill_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
